argmax: RTL and testbench

Frame-level classifier decision stage feeding the wake controller. Consumes a stream of signed per-class scores from the final dense layer, one score per beat and one frame per inference. Tracks the running maximum and emits a single one-hot class vector per frame on a valid/ready stream. The downstream wake block treats bit 0 of that vector as the wake-word class.

---
 rtl/wrd_pkg.sv | 22 ++
 rtl/argmax_cmp.sv | 35 +++
 rtl/argmax.sv | 152 +++++++++++++++
 tb/tb_argmax.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wrd_pkg.sv
// Shared wake-word decision definitions.
// Holds the argmax state encodings and the default frame geometry, so the
// argmax stage and the wake controller agree on class count and score width.
package wrd_pkg;

    // Default frame geometry shared by argmax and wake
    localparam int ARGMAX_NUM_CLASSES = 3;
    localparam int ARGMAX_DATA_WIDTH  = 32;

    // Argmax control states
    typedef enum logic {
        ARGMAX_COLLECT = 1'd0,
        ARGMAX_EMIT    = 1'd1
    } argmax_state_e;

    // Index width for a class count. A single class still needs one bit,
    // because $clog2(1) is 0.
    function automatic int argmax_idx_width(input int num_classes);
        return (num_classes > 1) ? $clog2(num_classes) : 1;
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Signed compare-and-select for the argmax running maximum.
// The candidate wins only on a strictly greater score, so on a tie the
// incumbent stays. The incumbent always has the lower index, so a tie keeps
// the lower class.
module argmax_cmp
    import wrd_pkg::*;
#(
    parameter int DATA_WIDTH = ARGMAX_DATA_WIDTH,
    parameter int IDX_W      = 2
) (
    input  logic signed [DATA_WIDTH-1:0] cand_score,
    input  logic        [IDX_W-1:0]      cand_idx,
    input  logic signed [DATA_WIDTH-1:0] inc_score,
    input  logic        [IDX_W-1:0]      inc_idx,
    output logic signed [DATA_WIDTH-1:0] win_score,
    output logic        [IDX_W-1:0]      win_idx
);

    logic cand_wins;

    // Both operands are declared signed, so this is a full-width
    // two's-complement compare.
    assign cand_wins = (cand_score > inc_score);

    // Select the winning score and index
    always_comb begin
        win_score = inc_score;
        win_idx   = inc_idx;
        if (cand_wins) begin
            win_score = cand_score;
            win_idx   = cand_idx;
        end
    end

endmodule

// File: rtl/argmax.sv
// Frame-level argmax decision stage feeding the wake controller.
// The block takes one signed class score per beat and keeps the running best.
// On the last beat of a frame it registers a one-hot winner and holds it on
// a valid/ready stream until the downstream accepts it.
// Optional feature: define ARGMAX_THRESH_EN to blank the one-hot output
// (data_o = 0, valid_o still 1) when the winning score is below THRESHOLD.
module argmax
    import wrd_pkg::*;
#(
    parameter int                          NUM_CLASSES = ARGMAX_NUM_CLASSES,
    parameter int                          DATA_WIDTH  = ARGMAX_DATA_WIDTH,
    parameter logic signed [DATA_WIDTH-1:0] THRESHOLD  = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         valid_i,
    input  logic                         last_i,
    output logic                         ready_o,
    output logic [NUM_CLASSES-1:0]       data_o,
    output logic                         valid_o,
    output logic                         last_o,
    input  logic                         ready_i
);

    localparam int               IDX_W    = argmax_idx_width(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    argmax_state_e                state_reg;
    logic [IDX_W-1:0]             idx_reg;
    // Set once beat NUM_CLASSES-1 has been taken. Any later beats in the
    // same frame are accepted but do not take part in the comparison.
    logic                         full_reg;
    logic signed [DATA_WIDTH-1:0] best_score_reg;
    logic [IDX_W-1:0]             best_idx_reg;
    logic [NUM_CLASSES-1:0]       data_reg;
    logic                         valid_reg;
    logic                         last_reg;

    logic signed [DATA_WIDTH-1:0] cmp_score;
    logic [IDX_W-1:0]             cmp_idx;
    logic signed [DATA_WIDTH-1:0] best_score_next;
    logic [IDX_W-1:0]             best_idx_next;
    logic [NUM_CLASSES-1:0]       onehot_next;
    logic [NUM_CLASSES-1:0]       decision_next;

    // ready_o depends only on state, so it does not combinationally follow
    // any input.
    assign ready_o = (state_reg == ARGMAX_COLLECT);
    assign data_o  = data_reg;
    assign valid_o = valid_reg;
    assign last_o  = last_reg;

    // The incoming beat is the candidate and the running best is the
    // incumbent.
    argmax_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_cmp (
        .cand_score (data_i),
        .cand_idx   (idx_reg),
        .inc_score  (best_score_reg),
        .inc_idx    (best_idx_reg),
        .win_score  (cmp_score),
        .win_idx    (cmp_idx)
    );

    // Running best including the current beat. Beat 0 seeds the best value
    // unconditionally. Beats past the class count leave the best unchanged.
    always_comb begin
        best_score_next = best_score_reg;
        best_idx_next   = best_idx_reg;
        if (!full_reg) begin
            if (idx_reg == '0) begin
                best_score_next = data_i;
                best_idx_next   = '0;
            end else begin
                best_score_next = cmp_score;
                best_idx_next   = cmp_idx;
            end
        end
    end

    // One-hot decode of the winning index. Bit gi is class gi.
    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_onehot
            assign onehot_next[gi] = (best_idx_next == IDX_W'(gi));
        end
    endgenerate

`ifdef ARGMAX_THRESH_EN
    // A winner below the minimum score is reported as "no class" but the
    // frame still produces a decision beat.
    assign decision_next = (best_score_next < THRESHOLD) ? '0 : onehot_next;
`else
    logic thresh_unused;
    assign thresh_unused = ^THRESHOLD;
    assign decision_next = onehot_next;
`endif

    // Control FSM, running best and registered decision outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg      <= ARGMAX_COLLECT;
            idx_reg        <= '0;
            full_reg       <= 1'b0;
            best_score_reg <= '0;
            best_idx_reg   <= '0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            last_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ARGMAX_COLLECT: begin
                    if (valid_i) begin
                        best_score_reg <= best_score_next;
                        best_idx_reg   <= best_idx_next;
                        // Saturate the index at the last class. The full flag
                        // marks that every class slot has been seen.
                        if (idx_reg == LAST_IDX) begin
                            full_reg <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                        if (last_i) begin
                            state_reg <= ARGMAX_EMIT;
                            data_reg  <= decision_next;
                            valid_reg <= 1'b1;
                            last_reg  <= 1'b1;
                        end
                    end
                end
                ARGMAX_EMIT: begin
                    // Hold the decision until it is taken, then start a
                    // fresh frame.
                    if (ready_i) begin
                        state_reg <= ARGMAX_COLLECT;
                        data_reg  <= '0;
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                        idx_reg   <= '0;
                        full_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ARGMAX_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax.sv
// Directed bench for argmax with an expected-decision scoreboard.
// Expected one-hot results come from a small reference argmax over each
// frame's scores. The threshold frames are included only when
// ARGMAX_THRESH_EN is defined.
module tb_argmax;
    import wrd_pkg::*;

    localparam int NC = 3;
    localparam int DW = 32;
`ifdef ARGMAX_THRESH_EN
    localparam int TH = 10;
`else
    localparam int TH = 0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic signed [DW-1:0] data_i;
    logic                 valid_i;
    logic                 last_i;
    logic                 ready_o;
    logic [NC-1:0]        data_o;
    logic                 valid_o;
    logic                 last_o;
    logic                 ready_i;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [NC-1:0] exp_q[$];

    argmax #(
        .NUM_CLASSES (NC),
        .DATA_WIDTH  (DW),
        .THRESHOLD   (DW'(TH))
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .ready_i (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference argmax: the first NC beats count, strict > keeps the lower
    // index on ties, and the optional threshold blanks the result.
    function automatic logic [NC-1:0] model(input int s[$]);
        int n;
        int best;
        int bi;
        logic [NC-1:0] r;
        n    = (s.size() < NC) ? s.size() : NC;
        best = s[0];
        bi   = 0;
        for (int k = 1; k < n; k++) begin
            if (s[k] > best) begin
                best = s[k];
                bi   = k;
            end
        end
        r     = '0;
        r[bi] = 1'b1;
`ifdef ARGMAX_THRESH_EN
        if (best < TH) r = '0;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one frame on negedges with last on the final beat. On return the
    // bench is at the negedge just after the last beat was accepted.
    task automatic drive_frame(input int s[$]);
        exp_q.push_back(model(s));
        for (int k = 0; k < s.size(); k++) begin
            @(negedge clk);
            data_i  = DW'(s[k]);
            valid_i = 1'b1;
            last_i  = (k == s.size() - 1);
        end
        @(negedge clk);
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    // Wait (bounded) for the decision, then check latency, data and flags
    // against the scoreboard.
    task automatic expect_decision(input string tag);
        int waited;
        logic [NC-1:0] e;
        waited = 0;
        while (!valid_o && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_latency"}, 32'(waited), 32'd0);
        e = '1;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check({tag, "_data"}, 32'(data_o), 32'(e));
        check({tag, "_last"}, 32'(last_o), 32'd1);
        check({tag, "_ready_o"}, 32'(ready_o), 32'd0);
        $display("frame %s: data_o=%b valid_o=%b last_o=%b", tag, data_o, valid_o, last_o);
    endtask

    // With ready_i high, the decision lasts one cycle and then COLLECT resumes.
    task automatic expect_release(input string tag);
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(valid_o), 32'd0);
        check({tag, "_data_clr"}, 32'(data_o), 32'd0);
        check({tag, "_ready_back"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        int fr[$];
        logic [NC-1:0] held;

        rst_n   = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_ready_o", 32'(ready_o), 32'd1);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_last_o", 32'(last_o), 32'd0);
        check("rst_data_o", 32'(data_o), 32'd0);
        rst_n = 1'b1;

        // Basic frame, then signed handling, then a three-way tie
        fr = '{5, 20, -3};
        drive_frame(fr);
        expect_decision("basic");
        expect_release("basic");

        fr = '{-100, -100, -7};
        drive_frame(fr);
        expect_decision("signed");
        expect_release("signed");

        fr = '{7, 7, 7};
        drive_frame(fr);
        expect_decision("tie");
        expect_release("tie");

        // Backpressure: hold the decision while new beats are offered
        ready_i = 1'b0;
        fr = '{1, 9, 2};
        held = model(fr);
        drive_frame(fr);
        expect_decision("hold");
        data_i  = DW'(1000);
        valid_i = 1'b1;
        last_i  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_data", 32'(data_o), 32'(held));
            check("hold_valid", 32'(valid_o), 32'd1);
            check("hold_ready_o", 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        ready_i = 1'b1;
        expect_release("hold");

        // Short and over-long frames
        fr = '{4, 8};
        drive_frame(fr);
        expect_decision("short");
        expect_release("short");

        fr = '{1, 2, 3, 99};
        drive_frame(fr);
        expect_decision("long");
        expect_release("long");

        // Reset in the middle of a frame, after two beats
        @(negedge clk);
        data_i = DW'(50); valid_i = 1'b1; last_i = 1'b0;
        @(negedge clk);
        data_i = DW'(60);
        @(negedge clk);
        valid_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midframe_rst_valid", 32'(valid_o), 32'd0);
        check("midframe_rst_data", 32'(data_o), 32'd0);
        check("midframe_rst_ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a decision is held
        ready_i = 1'b0;
        fr = '{2, 1, 0};
        drive_frame(fr);
        expect_decision("emit_pre_rst");
        #1 rst_n = 1'b0;
        #1;
        check("emit_rst_valid", 32'(valid_o), 32'd0);
        check("emit_rst_last", 32'(last_o), 32'd0);
        check("emit_rst_data", 32'(data_o), 32'd0);
        check("emit_rst_ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst_n   = 1'b1;
        ready_i = 1'b1;

        fr = '{0, 0, 6};
        drive_frame(fr);
        expect_decision("fresh");
        expect_release("fresh");

`ifdef ARGMAX_THRESH_EN
        fr = '{3, 9, 1};
        drive_frame(fr);
        expect_decision("thresh_below");
        check("thresh_below_valid", 32'(valid_o), 32'd1);
        expect_release("thresh_below");

        fr = '{3, 12, 1};
        drive_frame(fr);
        expect_decision("thresh_above");
        expect_release("thresh_above");
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
